// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory stage of the 16-bit MIPS
// pipeline. The execute stage and the hazard unit import the same package,
// so the op encoding is defined in exactly one place.
package dm_pkg;

  localparam int DW   = 16;  // datapath width
  localparam int RW_W = 5;   // register index width

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_ALU   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_e;

  // True for ops that produce a register write-back.
  function automatic logic writes_back(input op_e op);
    return (op == OP_ALU) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/dm_if.sv
// dm_if: bundle between execute/hazard logic and the data-memory stage.
//   master : execute side, drives ans_ex/BR_ex/RW_ex/op_ex/stall/flush and
//            observes the stage outputs.
//   slave  : the data-memory stage itself.
//   RW_dm_1/ans_dm_1 : write-back port towards the register bank.
//   load_in_dm_0/RW_dm_0 : hazard and forwarding information from dm_0.
interface dm_if;
  import dm_pkg::*;

  logic [DW-1:0]   ans_ex;
  logic [DW-1:0]   BR_ex;
  logic [RW_W-1:0] RW_ex;
  logic [1:0]      op_ex;
  logic            stall;
  logic            flush;
  logic [RW_W-1:0] RW_dm_1;
  logic [DW-1:0]   ans_dm_1;
  logic            load_in_dm_0;
  logic [RW_W-1:0] RW_dm_0;

  modport master (
    output ans_ex, BR_ex, RW_ex, op_ex, stall, flush,
    input  RW_dm_1, ans_dm_1, load_in_dm_0, RW_dm_0
  );

  modport slave (
    input  ans_ex, BR_ex, RW_ex, op_ex, stall, flush,
    output RW_dm_1, ans_dm_1, load_in_dm_0, RW_dm_0
  );

endinterface

// File: rtl/dm_ram.sv
// dm_ram: 2**AW x 16 word-addressed data memory.
//   clk   : write clock
//   we    : write enable, write lands on the rising edge
//   waddr/wdata : write port
//   raddr/rdata : combinational read port
// The array is never reset. With INIT_ZERO=1 it starts at all zeros via a
// declaration initializer (honoured by simulators and by FPGA RAM init).
module dm_ram
  import dm_pkg::*;
#(
  parameter int AW        = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  generate
    if (INIT_ZERO) begin : g_init
      logic [DW-1:0] mem [DEPTH] = '{default: '0};

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
    end else begin : g_noinit
      logic [DW-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/dm_stage.sv
// dm_stage: data-memory stage between execute and the register bank.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : dm_if slave; execute inputs in, write-back/hazard info out
// dm_0 captures the execute result; on the following edge dm_1 registers the
// write-back pair (ALU result or loaded word) while stores hit the memory.
// "No write-back" is encoded as writing 0 to R0 because the register bank
// writes every cycle.
module dm_stage
  import dm_pkg::*;
#(
  parameter int AW        = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input logic  clk,
  input logic  rst_n,
  dm_if.slave  bus
);

  // dm_0
  op_e             op_q,    op_d;
  logic [DW-1:0]   addr_q,  addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [RW_W-1:0] rw_q,    rw_d;
  // dm_1
  logic [RW_W-1:0] rw1_q,   rw1_d;
  logic [DW-1:0]   ans1_q,  ans1_d;

  logic            mem_we;
  logic [DW-1:0]   mem_rdata;

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rw1_d   = rw1_q;
    ans1_d  = ans1_q;
    mem_we  = 1'b0;

    // stall freezes everything, including a pending flush and store
    if (!bus.stall) begin
      if (bus.flush) begin
        op_d    = OP_NOP;
        addr_d  = '0;
        wdata_d = '0;
        rw_d    = '0;
      end else begin
        op_d    = op_e'(bus.op_ex);
        addr_d  = bus.ans_ex;
        wdata_d = bus.BR_ex;
        // keep RW_dm_0 meaningful for forwarding: only real write-backs
        rw_d    = writes_back(op_e'(bus.op_ex)) ? bus.RW_ex : '0;
      end

      unique case (op_q)
        OP_ALU: begin
          rw1_d  = rw_q;
          ans1_d = addr_q;
        end
        OP_LOAD: begin
          rw1_d  = rw_q;
          ans1_d = mem_rdata;
        end
        OP_STORE: begin
          mem_we = 1'b1;
          rw1_d  = '0;
          ans1_d = '0;
        end
        default: begin
          rw1_d  = '0;
          ans1_d = '0;
        end
      endcase

      // R0 must never receive a nonzero value
      if (rw_q == '0) ans1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= '0;
      rw1_q   <= '0;
      ans1_q  <= '0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rw1_q   <= rw1_d;
      ans1_q  <= ans1_d;
    end
  end

  // Only the low AW address bits select a word; upper bits wrap silently.
  dm_ram #(
    .AW        (AW),
    .INIT_ZERO (INIT_ZERO)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .raddr (addr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.RW_dm_1      = rw1_q;
  assign bus.ans_dm_1     = ans1_q;
  assign bus.load_in_dm_0 = (op_q == OP_LOAD);
  assign bus.RW_dm_0      = rw_q;

endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: directed and randomized checks of dm_stage against a
// transaction-level model (one in-flight instruction slot, a write-back pair
// and a plain memory array).
module tb_dm_stage;
  import dm_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_if bus ();

  dm_stage #(
    .AW        (AW),
    .INIT_ZERO (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] d;
    logic [4:0]  rd;
  } instr_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  instr_t      m_slot;
  logic [4:0]  m_rw1;
  logic [15:0] m_ans1;
  logic [15:0] m_mem [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dest_of(input instr_t i);
    return (i.op == 2'd1 || i.op == 2'd2) ? i.rd : 5'd0;
  endfunction

  task automatic model_reset();
    m_slot = '{op: 2'd0, a: 16'h0, d: 16'h0, rd: 5'd0};
    m_rw1  = '0;
    m_ans1 = '0;
  endtask

  // One clock edge in the model: the instruction in the slot retires, the
  // new one (or a bubble) enters.
  task automatic model_edge(input instr_t nw, input logic stl, input logic fl);
    logic [4:0]  d;
    logic [15:0] v;
    if (stl) return;
    d = dest_of(m_slot);
    v = 16'h0;
    case (m_slot.op)
      2'd1: v = m_slot.a;
      2'd2: v = m_mem[m_slot.a[AW-1:0]];
      2'd3: m_mem[m_slot.a[AW-1:0]] = m_slot.d;
      default: ;
    endcase
    m_rw1  = d;
    m_ans1 = (d == 5'd0) ? 16'h0 : v;
    m_slot = fl ? '{op: 2'd0, a: 16'h0, d: 16'h0, rd: 5'd0} : nw;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".rw_dm_1"},  32'(bus.RW_dm_1),      32'(m_rw1));
    chk({ctx, ".ans_dm_1"}, 32'(bus.ans_dm_1),     32'(m_ans1));
    chk({ctx, ".load_in"},  32'(bus.load_in_dm_0), 32'(m_slot.op == 2'd2));
    chk({ctx, ".rw_dm_0"},  32'(bus.RW_dm_0),      32'(dest_of(m_slot)));
  endtask

  // Drive one transaction, clock it, update the model and compare 1 ns later.
  task automatic step(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                      input logic [4:0] rd, input logic stl, input logic fl, input string ctx);
    instr_t nw;
    bus.op_ex  = op;
    bus.ans_ex = a;
    bus.BR_ex  = d;
    bus.RW_ex  = rd;
    bus.stall  = stl;
    bus.flush  = fl;
    nw = '{op: op, a: a, d: d, rd: rd};
    @(posedge clk);
    model_edge(nw, stl, fl);
    #1;
    $display("[TB] %s op=%0d a=%h d=%h rd=%0d st=%0b fl=%0b -> rw1=%0d ans1=%h ld0=%0b rw0=%0d",
             ctx, op, a, d, rd, stl, fl, bus.RW_dm_1, bus.ans_dm_1, bus.load_in_dm_0, bus.RW_dm_0);
    check_outputs(ctx);
  endtask

  task automatic nop(input string ctx);
    step(2'd0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, ctx);
  endtask

  // Asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string ctx);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({ctx, ".async_rw1"},  32'(bus.RW_dm_1),      32'd0);
    chk({ctx, ".async_ans1"}, 32'(bus.ans_dm_1),     32'd0);
    chk({ctx, ".async_ld0"},  32'(bus.load_in_dm_0), 32'd0);
    chk({ctx, ".async_rw0"},  32'(bus.RW_dm_0),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.op_ex  = 2'($urandom);
      bus.ans_ex = 16'($urandom);
      bus.BR_ex  = 16'($urandom);
      bus.RW_ex  = 5'($urandom);
      bus.stall  = 1'b0;
      bus.flush  = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("post_release");

    // ALU pass-through and R0 suppression
    step(2'd1, 16'h1234, 16'h0, 5'd5, 1'b0, 1'b0, "alu");
    nop("alu_wb");
    chk("alu_rw", 32'(bus.RW_dm_1), 32'd5);
    chk("alu_ans", 32'(bus.ans_dm_1), 32'h1234);
    step(2'd1, 16'hFFFF, 16'h0, 5'd0, 1'b0, 1'b0, "alu_r0");
    nop("alu_r0_wb");
    chk("alu_r0_ans", 32'(bus.ans_dm_1), 32'd0);

    // store then load back-to-back
    step(2'd3, 16'h0010, 16'hBEEF, 5'd9, 1'b0, 1'b0, "st");
    step(2'd2, 16'h0010, 16'h0, 5'd7, 1'b0, 1'b0, "ld");
    chk("st_slot_rw", 32'(bus.RW_dm_1), 32'd0);
    chk("st_slot_ans", 32'(bus.ans_dm_1), 32'd0);
    chk("ld_in_dm0", 32'(bus.load_in_dm_0), 32'd1);
    nop("ld_wb");
    chk("ld_rw", 32'(bus.RW_dm_1), 32'd7);
    chk("ld_ans", 32'(bus.ans_dm_1), 32'hBEEF);
    chk("ld_in_gone", 32'(bus.load_in_dm_0), 32'd0);

    // address wrap
    step(2'd3, 16'h0305, 16'h00AA, 5'd0, 1'b0, 1'b0, "wrap_st");
    step(2'd2, 16'h0005, 16'h0, 5'd3, 1'b0, 1'b0, "wrap_ld");
    nop("wrap_wb");
    chk("wrap_ans", 32'(bus.ans_dm_1), 32'h00AA);

    // stall with a store presented, then released
    for (int i = 0; i < 3; i++) step(2'd3, 16'h0003, 16'h5555, 5'd0, 1'b1, 1'b0, "st_stall");
    step(2'd3, 16'h0003, 16'h5555, 5'd0, 1'b0, 1'b0, "st_go");
    step(2'd2, 16'h0003, 16'h0, 5'd4, 1'b0, 1'b0, "st_ld");
    nop("st_ld_wb");
    chk("stall_st_ans", 32'(bus.ans_dm_1), 32'h5555);

    // flush kills a load
    step(2'd2, 16'h0010, 16'h0, 5'd9, 1'b0, 1'b1, "flush_ld");
    chk("flush_ld_in", 32'(bus.load_in_dm_0), 32'd0);
    nop("flush_wb");
    chk("flush_rw", 32'(bus.RW_dm_1), 32'd0);

    // stall beats flush
    step(2'd1, 16'h0077, 16'h0, 5'd2, 1'b0, 1'b0, "sf_alu");
    step(2'd0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, "sf_both");
    nop("sf_wb");
    chk("sf_rw", 32'(bus.RW_dm_1), 32'd2);
    chk("sf_ans", 32'(bus.ans_dm_1), 32'h0077);

    // NOP stream with random payload
    for (int i = 0; i < 16; i++)
      step(2'd0, 16'($urandom), 16'($urandom), 5'($urandom), 1'b0, 1'b0, "nop_rand");

    // mid-stream asynchronous reset with a load in flight
    step(2'd2, 16'h0010, 16'h0, 5'd6, 1'b0, 1'b0, "pre_rst");
    async_reset("mid_rst");

    // randomized traffic, small address window so loads hit earlier stores
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
      step(2'($urandom), a, 16'($urandom), 5'($urandom),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 12), "rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
